// File: rtl/pmodenc_axi_responder.sv
// Purpose : AXI4-Lite register file for the PmodENC: CTRL/STATUS/COUNT/SCRATCH plus an x4 quadrature decoder and a level IRQ.
// Latency : write lands on the AW/W handshake edge and BVALID follows one cycle later; RDATA is registered on the AR handshake and RVALID follows one cycle later; encoder pins reach COUNT on the third ACLK edge.
// Backpres: one write and one read outstanding at most; AW/W are not accepted while BVALID is high, AR is not accepted while RVALID is high.
//
// Ports: ACLK/ARESET (async, active-high); S_AXI_* AXI4-Lite slave, single beat, OKAY-only responses;
//        ENC_A/ENC_B quadrature pins, ENC_BTN/ENC_SWT button and switch (all asynchronous); IRQ = irq_en & chg.
module pmodenc_axi_responder #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic                            ENC_A,
  input  logic                            ENC_B,
  input  logic                            ENC_BTN,
  input  logic                            ENC_SWT,
  output logic                            IRQ
);

  // Protection bits and byte-offset address bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  // Synchronisers: two flops per pin, plus a third stage holding the previous A/B pair.
  logic a_s1, a_s2, b_s1, b_s2, btn_s1, btn_s2, swt_s1, swt_s2;
  logic [1:0] ab_prv;

  // Register state
  logic        enable, irq_en, dir, err, chg;
  logic [31:0] count, scratch;

  // Write decode (AWREADY and WREADY always move together)
  logic       wr_en, ctrl_wr, stat_w1c, clr;
  logic [1:0] wr_sel;
  assign wr_en    = S_AXI_AWREADY & S_AXI_AWVALID & S_AXI_WREADY & S_AXI_WVALID;
  assign wr_sel   = S_AXI_AWADDR[3:2];
  assign ctrl_wr  = wr_en && (wr_sel == 2'd0) && S_AXI_WSTRB[0];
  assign stat_w1c = wr_en && (wr_sel == 2'd1) && S_AXI_WSTRB[0];
  assign clr      = ctrl_wr & S_AXI_WDATA[1];

  // Quadrature decode on the synchronised pair against the previous pair.
  // Up order is 00 -> 10 -> 11 -> 01 -> 00; any other single-bit change is a down step.
  logic [1:0] ab_cur, ab_diff;
  logic       step_vld, step_up, step_err, step_cnt, err_set;
  always_comb begin
    ab_cur   = {a_s2, b_s2};
    ab_diff  = ab_cur ^ ab_prv;
    step_vld = (ab_diff == 2'b01) || (ab_diff == 2'b10);
    step_err = (ab_diff == 2'b11);
    step_up  = ((ab_prv == 2'b00) && (ab_cur == 2'b10)) ||
               ((ab_prv == 2'b10) && (ab_cur == 2'b11)) ||
               ((ab_prv == 2'b11) && (ab_cur == 2'b01)) ||
               ((ab_prv == 2'b01) && (ab_cur == 2'b00));
    step_cnt = enable & step_vld;
    err_set  = enable & step_err;
  end

  // Read mux, sampled on the AR handshake edge
  logic        rd_en;
  logic [31:0] rd_mux;
  assign rd_en = S_AXI_ARREADY & S_AXI_ARVALID;
  always_comb begin
    rd_mux = 32'd0;
    case (S_AXI_ARADDR[3:2])
      2'd0: rd_mux = {29'd0, irq_en, 1'b0, enable};
      2'd1: rd_mux = {27'd0, chg, err, dir, swt_s2, btn_s2};
      2'd2: rd_mux = count;
      2'd3: rd_mux = scratch;
      default: rd_mux = 32'd0;
    endcase
  end

  assign S_AXI_BRESP = 2'b00;
  assign S_AXI_RRESP = 2'b00;
  assign IRQ         = irq_en & chg;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      a_s1 <= 1'b0; a_s2 <= 1'b0; b_s1 <= 1'b0; b_s2 <= 1'b0;
      btn_s1 <= 1'b0; btn_s2 <= 1'b0; swt_s1 <= 1'b0; swt_s2 <= 1'b0;
      ab_prv        <= 2'b00;
      enable        <= 1'b0;
      irq_en        <= 1'b0;
      dir           <= 1'b0;
      err           <= 1'b0;
      chg           <= 1'b0;
      count         <= 32'd0;
      scratch       <= 32'd0;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= 32'd0;
    end else begin
      a_s1   <= ENC_A;   a_s2   <= a_s1;
      b_s1   <= ENC_B;   b_s2   <= b_s1;
      btn_s1 <= ENC_BTN; btn_s2 <= btn_s1;
      swt_s1 <= ENC_SWT; swt_s2 <= swt_s1;
      ab_prv <= ab_cur;

      // Clear beats a simultaneous step; counting wraps naturally modulo 2^32.
      if (clr)
        count <= 32'd0;
      else if (step_cnt)
        count <= step_up ? count + 32'd1 : count - 32'd1;
      if (step_cnt)
        dir <= step_up;

      // Sticky flags: a set in the same cycle as a W1C wins.
      if (step_cnt)
        chg <= 1'b1;
      else if (stat_w1c && S_AXI_WDATA[4])
        chg <= 1'b0;
      if (err_set)
        err <= 1'b1;
      else if (stat_w1c && S_AXI_WDATA[3])
        err <= 1'b0;

      if (ctrl_wr) begin
        enable <= S_AXI_WDATA[0];
        irq_en <= S_AXI_WDATA[2];
      end
      if (wr_en && (wr_sel == 2'd3)) begin
        for (int i = 0; i < 4; i++)
          if (S_AXI_WSTRB[i])
            scratch[8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
      end

      // Write channel
      if (S_AXI_AWREADY) begin
        S_AXI_AWREADY <= 1'b0;
        S_AXI_WREADY  <= 1'b0;
      end else if (S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID) begin
        S_AXI_AWREADY <= 1'b1;
        S_AXI_WREADY  <= 1'b1;
      end
      if (wr_en)
        S_AXI_BVALID <= 1'b1;
      else if (S_AXI_BVALID && S_AXI_BREADY)
        S_AXI_BVALID <= 1'b0;

      // Read channel
      if (S_AXI_ARREADY)
        S_AXI_ARREADY <= 1'b0;
      else if (S_AXI_ARVALID && !S_AXI_RVALID)
        S_AXI_ARREADY <= 1'b1;
      if (rd_en) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= rd_mux;
      end else if (S_AXI_RVALID && S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pmodenc_axi_responder.sv
// Purpose : directed bench for pmodenc_axi_responder; reads are checked by a scoreboard monitor.
// Latency : waits on DUT handshakes are bounded; an expired bound is reported as a failure.
// Backpres: BREADY/RREADY are held low in chosen phases to stall the responder.
module tb_pmodenc_axi_responder;

  localparam logic [3:0] A_CTRL = 4'h0, A_STAT = 4'h4, A_CNT = 4'h8, A_SCR = 4'hC;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot = 3'd0, arprot = 3'd0;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        enc_a, enc_b, enc_btn, enc_swt, irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [3:0]  addr_q[$];

  always #5 clk = ~clk;

  pmodenc_axi_responder #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .ACLK(clk), .ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .ENC_A(enc_a), .ENC_B(enc_b), .ENC_BTN(enc_btn), .ENC_SWT(enc_swt), .IRQ(irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: handshake never happened within its cycle budget", name);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: one compare per completed R handshake, BRESP per completed B handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (rvalid && rready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected: got %h with no read outstanding", rdata);
        end else begin
          logic [31:0] e;
          logic [3:0]  a;
          e = exp_q.pop_front();
          a = addr_q.pop_front();
          check($sformatf("rdata@%h", a), rdata, e);
          check("rresp", {30'd0, rresp}, 32'd0);
        end
      end
      if (bvalid && bready)
        check("bresp", {30'd0, bresp}, 32'd0);
    end
  end

  task automatic wait_aw;
    int n = 0;
    while (!awready && n < 50) begin @(posedge clk); #1; n++; end
    if (!awready) timeout_fail("aw_accept");
    else begin @(posedge clk); #1; end
    awvalid = 1'b0;
    wvalid  = 1'b0;
  endtask

  task automatic write_issue(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    wait_aw();
  endtask

  task automatic wait_b;
    int n = 0;
    while (!bvalid && n < 50) begin @(posedge clk); #1; n++; end
    if (!bvalid) timeout_fail("b_valid");
    n = 0;
    while (bvalid && n < 50) begin @(posedge clk); #1; n++; end
    if (bvalid) timeout_fail("b_done");
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    write_issue(a, d, s);
    wait_b();
  endtask

  task automatic read_issue(input logic [3:0] a, input logic [31:0] e);
    int n = 0;
    exp_q.push_back(e);
    addr_q.push_back(a);
    araddr = a;
    arvalid = 1'b1;
    while (!arready && n < 50) begin @(posedge clk); #1; n++; end
    if (!arready) timeout_fail("ar_accept");
    else begin @(posedge clk); #1; end
    arvalid = 1'b0;
  endtask

  task automatic wait_r;
    int n = 0;
    while (!rvalid && n < 50) begin @(posedge clk); #1; n++; end
    if (!rvalid) timeout_fail("r_valid");
    n = 0;
    while (rvalid && n < 50) begin @(posedge clk); #1; n++; end
    if (rvalid) timeout_fail("r_done");
  endtask

  task automatic axi_read(input logic [3:0] a, input logic [31:0] e);
    read_issue(a, e);
    wait_r();
  endtask

  task automatic enc(input logic a, input logic b);
    enc_a = a;
    enc_b = b;
    cycles(4);
  endtask

  initial begin
    int bad;
    int n;
    rst = 1'b1;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    enc_a = 0; enc_b = 0; enc_btn = 0; enc_swt = 0;
    cycles(3);
    check("rst_awready", {31'd0, awready}, 32'd0);
    check("rst_wready",  {31'd0, wready},  32'd0);
    check("rst_bvalid",  {31'd0, bvalid},  32'd0);
    check("rst_arready", {31'd0, arready}, 32'd0);
    check("rst_rvalid",  {31'd0, rvalid},  32'd0);
    check("rst_rdata",   rdata,            32'd0);
    check("rst_irq",     {31'd0, irq},     32'd0);
    rst = 1'b0;
    cycles(2);
    axi_read(A_CTRL, 32'h0);
    axi_read(A_STAT, 32'h0);
    axi_read(A_CNT,  32'h0);
    axi_read(A_SCR,  32'h0);

    // Register map: clear bit reads 0, W1C of clear flags leaves 0, COUNT ignores writes
    enc_btn = 1;
    axi_write(A_CTRL, 32'h7, 4'hF);
    axi_write(A_STAT, 32'h18, 4'hF);
    axi_write(A_CNT,  32'h3, 4'hF);
    axi_write(A_SCR,  32'h4, 4'hF);
    axi_read(A_CTRL, 32'h5);
    axi_read(A_STAT, 32'h1);
    axi_read(A_CNT,  32'h0);
    axi_read(A_SCR,  32'h4);

    // enable=0: step is ignored; switch visible
    enc_btn = 0; enc_swt = 1;
    axi_write(A_CTRL, 32'h0, 4'hF);
    enc(1, 0);
    axi_read(A_CNT,  32'h0);
    axi_read(A_STAT, 32'h2);
    enc_swt = 0;
    cycles(3);

    // 8 up steps from 10, then 3 down
    axi_write(A_CTRL, 32'h1, 4'hF);
    for (int i = 0; i < 2; i++) begin
      enc(1, 1); enc(0, 1); enc(0, 0); enc(1, 0);
    end
    axi_read(A_CNT,  32'd8);
    axi_read(A_STAT, 32'h14);
    enc(0, 0); enc(0, 1); enc(1, 1);
    axi_read(A_CNT,  32'd5);
    axi_read(A_STAT, 32'h10);

    // IRQ and chg W1C
    axi_write(A_STAT, 32'h10, 4'hF);
    axi_read(A_STAT, 32'h0);
    axi_write(A_CTRL, 32'h5, 4'hF);
    check("irq_idle", {31'd0, irq}, 32'd0);
    enc(1, 0);
    check("irq_step", {31'd0, irq}, 32'd1);
    axi_write(A_STAT, 32'h10, 4'hF);
    check("irq_w1c", {31'd0, irq}, 32'd0);
    axi_read(A_STAT, 32'h0);
    axi_read(A_CNT,  32'd4);

    // up step landing on the same edge as a chg W1C: set wins
    enc_a = 1; enc_b = 1;
    @(posedge clk); #1;
    axi_write(A_STAT, 32'h10, 4'hF);
    cycles(2);
    axi_read(A_STAT, 32'h14);
    check("irq_set_wins", {31'd0, irq}, 32'd1);
    axi_read(A_CNT, 32'd5);

    // both bits change at once: err, COUNT held
    axi_write(A_STAT, 32'h18, 4'hF);
    axi_read(A_STAT, 32'h4);
    enc(0, 0);
    axi_read(A_STAT, 32'hC);
    axi_read(A_CNT,  32'd5);
    axi_write(A_STAT, 32'h8, 4'hF);
    axi_read(A_STAT, 32'h4);

    // byte strobes on SCRATCH
    axi_write(A_SCR, 32'h0, 4'hF);
    axi_write(A_SCR, 32'hAABBCCDD, 4'b0101);
    axi_read(A_SCR, 32'h00BB00DD);

    // B stall: response held, second write not accepted
    bready = 0;
    write_issue(A_SCR, 32'h11223344, 4'hF);
    awaddr = A_SCR; wdata = 32'h55667788; wstrb = 4'hF;
    awvalid = 1; wvalid = 1;
    bad = 0;
    repeat (10) begin
      cycles(1);
      if (!bvalid || awready || wready) bad++;
    end
    check("b_stall", bad, 0);
    bready = 1;
    wait_aw();
    wait_b();
    axi_read(A_SCR, 32'h55667788);

    // R stall: RVALID and RDATA held
    rready = 0;
    read_issue(A_SCR, 32'h55667788);
    n = 0;
    while (!rvalid && n < 20) begin cycles(1); n++; end
    bad = 0;
    repeat (10) begin
      cycles(1);
      if (!rvalid || arready || rdata !== 32'h55667788) bad++;
    end
    check("r_stall", bad, 0);
    rready = 1;
    wait_r();

    // wrap below zero, then clear wins over a coincident down step
    axi_write(A_CTRL, 32'h3, 4'hF);
    axi_read(A_CNT, 32'h0);
    enc(0, 1);
    axi_read(A_CNT,  32'hFFFFFFFF);
    axi_read(A_STAT, 32'h10);
    enc_a = 1; enc_b = 1;
    @(posedge clk); #1;
    axi_write(A_CTRL, 32'h3, 4'hF);
    cycles(2);
    axi_read(A_CNT, 32'h0);

    // reset in the middle of a stalled read
    enc(0, 0);
    rready = 0;
    read_issue(A_SCR, 32'h55667788);
    n = 0;
    while (!rvalid && n < 20) begin cycles(1); n++; end
    rst = 1;
    #1;
    check("rst_mid_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_mid_bvalid", {31'd0, bvalid}, 32'd0);
    void'(exp_q.pop_front());
    void'(addr_q.pop_front());
    cycles(2);
    rst = 0;
    bad = 0;
    repeat (5) begin
      cycles(1);
      if (rvalid || bvalid) bad++;
    end
    check("no_resp_after_rst", bad, 0);
    rready = 1;
    axi_read(A_CTRL, 32'h0);
    axi_read(A_STAT, 32'h0);
    axi_read(A_CNT,  32'h0);
    axi_read(A_SCR,  32'h0);

    cycles(5);
    check("scoreboard_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

endmodule
